// File: rtl/padder_ctrl_pkg.sv
// Shared constants and state encoding for the SHA3-512 rate-block padder.
package padder_ctrl_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned RATE_WORDS = 18;
    localparam int unsigned RATE_BITS  = 576;
    localparam int unsigned CNT_W      = 5;

    localparam logic [7:0] PAD_FIRST = 8'h06;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

endpackage

// File: rtl/padder_ctrl_padder1.sv
// Formats the final partial message word: valid bytes kept, 0x06 appended, rest zero.
module padder1 (
    input  logic [31:0] in_word,
    input  logic [1:0]  byte_num,
    output logic [31:0] out_word_c
);
    import padder_ctrl_pkg::*;

    // Select how many leading bytes survive before the domain-separation byte
    always_comb begin
        out_word_c = '0;
        case (byte_num)
            2'd0:    out_word_c = {PAD_FIRST, 24'h000000};
            2'd1:    out_word_c = {in_word[31:24], PAD_FIRST, 16'h0000};
            2'd2:    out_word_c = {in_word[31:16], PAD_FIRST, 8'h00};
            default: out_word_c = {in_word[31:8], PAD_FIRST};
        endcase
    end

endmodule

// File: rtl/padder_ctrl.sv
// Assembles 32-bit message words into SHA3-512 rate blocks and applies pad10*1.
module padder_ctrl #(
    parameter int unsigned RATE_WORDS = padder_ctrl_pkg::RATE_WORDS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 in,
    input  logic                        in_ready,
    input  logic                        is_last,
    input  logic [1:0]                  byte_num,
    output logic                        buffer_full,
    output logic [32*RATE_WORDS-1:0]    out,
    output logic                        out_ready,
    output logic                        last_block,
    input  logic                        f_ack
);
    import padder_ctrl_pkg::*;

    localparam int unsigned OUT_W = WORD_W * RATE_WORDS;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(RATE_WORDS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_ready_q, out_ready_d;
    logic               last_block_q, last_block_d;
    logic               buffer_full_q, buffer_full_d;

    logic [WORD_W-1:0]  pad_word_c;
    logic [WORD_W-1:0]  word_c;
    logic               shift_c;
    logic               cnt_at_end_c;

    padder1 u_padder1 (
        .in_word    (in),
        .byte_num   (byte_num),
        .out_word_c (pad_word_c)
    );

    assign cnt_at_end_c = (cnt_q == CNT_END);

    // State register and block datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FILL;
            cnt_q         <= '0;
            out_q         <= '0;
            out_ready_q   <= 1'b0;
            last_block_q  <= 1'b0;
            buffer_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_ready_q   <= out_ready_d;
            last_block_q  <= last_block_d;
            buffer_full_q <= buffer_full_d;
        end
    end

    // Next-state, word selection and shift control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        out_ready_d  = out_ready_q;
        last_block_d = last_block_q;
        word_c       = '0;
        shift_c      = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (in_ready) begin
                    shift_c = 1'b1;
                    if (is_last) begin
                        word_c       = pad_word_c;
                        last_block_d = 1'b1;
                    end else begin
                        word_c = in;
                    end
                    if (cnt_at_end_c) begin
                        // Message ends exactly on the rate boundary: close the pad here
                        if (is_last) begin
                            word_c[7:0] = word_c[7:0] | PAD_LAST;
                        end
                        state_d     = ST_FULL;
                        out_ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (is_last) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                shift_c = 1'b1;
                if (cnt_at_end_c) begin
                    word_c[7:0] = PAD_LAST;
                    state_d     = ST_FULL;
                    out_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FULL: begin
                if (f_ack) begin
                    state_d      = ST_FILL;
                    cnt_d        = '0;
                    out_ready_d  = 1'b0;
                    last_block_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (shift_c) begin
            out_d = {out_q[OUT_W-WORD_W-1:0], word_c};
        end

        buffer_full_d = (state_d != ST_FILL);
    end

    assign out         = out_q;
    assign out_ready   = out_ready_q;
    assign last_block  = last_block_q;
    assign buffer_full = buffer_full_q;

endmodule

// File: tb/tb_padder_ctrl.sv
// Directed self-checking bench for padder_ctrl.
`timescale 1ns/1ps
module tb_padder_ctrl;

    logic         clk;
    logic         reset;
    logic [31:0]  in;
    logic         in_ready;
    logic         is_last;
    logic [1:0]   byte_num;
    logic         buffer_full;
    logic [575:0] out;
    logic         out_ready;
    logic         last_block;
    logic         f_ack;

    int checks;
    int failures;

    padder_ctrl #(.RATE_WORDS(18)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .last_block  (last_block),
        .f_ack       (f_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for exactly one accepting edge
    task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn);
        in       = w;
        in_ready = 1'b1;
        is_last  = last;
        byte_num = bn;
        step();
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = 2'd0;
        in       = 32'h0;
    endtask

    task automatic ack();
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out !== 576'h0 || out_ready !== 1'b0 || last_block !== 1'b0 || buffer_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: out_ready=%b last_block=%b buffer_full=%b out_nonzero=%b (want 0 0 0 0)",
                     out_ready, last_block, buffer_full, (out != 576'h0));
        end
        reset = 1'b0;
        step();
    endtask

    // 18 plain words 1..18, no is_last
    task automatic test_full_block();
        logic [575:0] exp;
        exp = '0;
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (buffer_full !== 1'b0 || out_ready !== 1'b0) begin
                failures++;
                $display("FAIL full_block_fill_flags[%0d]: buffer_full=%b out_ready=%b (want 0 0)", i, buffer_full, out_ready);
            end
            send(32'(i + 1), 1'b0, 2'd0);
            exp = {exp[543:0], 32'(i + 1)};
        end
        checks++;
        if (out_ready !== 1'b1 || buffer_full !== 1'b1 || last_block !== 1'b0) begin
            failures++;
            $display("FAIL full_block_flags: out_ready=%b buffer_full=%b last_block=%b (want 1 1 0)", out_ready, buffer_full, last_block);
        end
        checks++;
        if (out !== exp) begin
            failures++;
            $display("FAIL full_block_data: got %h want %h", out, exp);
        end
        ack();
        checks++;
        if (out_ready !== 1'b0 || buffer_full !== 1'b0 || last_block !== 1'b0) begin
            failures++;
            $display("FAIL full_block_ack: out_ready=%b buffer_full=%b last_block=%b (want 0 0 0)", out_ready, buffer_full, last_block);
        end
    endtask

    // is_last at index k with given byte_num; checks latency, first/last words
    task automatic test_last_at(input int k, input logic [31:0] w, input logic [1:0] bn,
                                input logic [31:0] exp_last_word);
        int n;
        for (int i = 0; i < k; i++) send(32'hA0000000 + 32'(i), 1'b0, 2'd0);
        send(w, 1'b1, bn);
        checks++;
        if (last_block !== 1'b1 || buffer_full !== 1'b1) begin
            failures++;
            $display("FAIL last_k%0d_flags: last_block=%b buffer_full=%b (want 1 1)", k, last_block, buffer_full);
        end
        n = 0;
        while (out_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 17 - k) begin
            failures++;
            $display("FAIL last_k%0d_latency: got %0d extra cycles want %0d", k, n, 17 - k);
        end
        checks++;
        if (out[32*(17-k) +: 32] !== exp_last_word) begin
            failures++;
            $display("FAIL last_k%0d_word: got %h want %h", k, out[32*(17-k) +: 32], exp_last_word);
        end
        if (k < 17) begin
            checks++;
            if (out[31:0] !== 32'h00000080) begin
                failures++;
                $display("FAIL last_k%0d_tail: got %h want 00000080", k, out[31:0]);
            end
        end
        ack();
        checks++;
        if (out_ready !== 1'b0 || last_block !== 1'b0 || buffer_full !== 1'b0) begin
            failures++;
            $display("FAIL last_k%0d_ack: out_ready=%b last_block=%b buffer_full=%b (want 0 0 0)", k, out_ready, last_block, buffer_full);
        end
    endtask

    // Single is_last word, byte_num 0: whole block image is fixed
    task automatic test_single_last();
        logic [575:0] exp;
        exp = {32'h06000000, 512'h0, 32'h00000080};
        send(32'hDEADBEEF, 1'b1, 2'd0);
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (out_ready !== 1'b0 || buffer_full !== 1'b1) begin
                failures++;
                $display("FAIL single_pad_cycle[%0d]: out_ready=%b buffer_full=%b (want 0 1)", i, out_ready, buffer_full);
            end
            step();
        end
        checks++;
        if (out_ready !== 1'b1 || last_block !== 1'b1 || out !== exp) begin
            failures++;
            $display("FAIL single_last: out_ready=%b last_block=%b out=%h want %h", out_ready, last_block, out, exp);
        end
        ack();
    endtask

    // Aligned last word at k=17, byte_num 3 -> 0x11223386, no PAD cycles
    task automatic test_last_aligned();
        logic [575:0] exp;
        exp = '0;
        for (int i = 0; i < 17; i++) begin
            send(32'h5000 + 32'(i), 1'b0, 2'd0);
            exp = {exp[543:0], 32'h5000 + 32'(i)};
        end
        send(32'h11223344, 1'b1, 2'd3);
        exp = {exp[543:0], 32'h11223386};
        checks++;
        if (out_ready !== 1'b1 || last_block !== 1'b1 || out !== exp) begin
            failures++;
            $display("FAIL last_aligned: out_ready=%b last_block=%b out=%h want %h", out_ready, last_block, out, exp);
        end
        ack();
    endtask

    // in_ready held through FULL; nothing consumed until f_ack
    task automatic test_backpressure();
        logic [575:0] exp;
        exp = '0;
        for (int i = 0; i < 18; i++) begin
            send(32'h100 + 32'(i), 1'b0, 2'd0);
            exp = {exp[543:0], 32'h100 + 32'(i)};
        end
        in       = 32'hDEADDEAD;
        in_ready = 1'b1;
        is_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (buffer_full !== 1'b1 || out_ready !== 1'b1 || last_block !== 1'b0 || out !== exp) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: buffer_full=%b out_ready=%b last_block=%b out=%h", i, buffer_full, out_ready, last_block, out);
            end
        end
        is_last = 1'b0;
        f_ack   = 1'b1;
        step();
        f_ack = 1'b0;
        checks++;
        if (buffer_full !== 1'b0 || out_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: buffer_full=%b out_ready=%b (want 0 0)", buffer_full, out_ready);
        end
        in = 32'hCAFE0001;
        step();
        in_ready = 1'b0;
        for (int i = 1; i < 18; i++) send(32'h200 + 32'(i), 1'b0, 2'd0);
        checks++;
        if (out_ready !== 1'b1 || out[575:544] !== 32'hCAFE0001 || out[31:0] !== 32'h211) begin
            failures++;
            $display("FAIL backpressure_word0: out_ready=%b word0=%h word17=%h want 1 cafe0001 00000211", out_ready, out[575:544], out[31:0]);
        end
        ack();
    endtask

    // Reset in the middle of PAD; next block must start at word 0
    task automatic test_reset_mid_pad();
        logic [575:0] exp;
        for (int i = 0; i < 3; i++) send(32'h77 + 32'(i), 1'b0, 2'd0);
        send(32'h12345678, 1'b1, 2'd2);
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out !== 576'h0 || out_ready !== 1'b0 || last_block !== 1'b0 || buffer_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pad: out_ready=%b last_block=%b buffer_full=%b out_nonzero=%b (want 0 0 0 0)",
                     out_ready, last_block, buffer_full, (out != 576'h0));
        end
        step();
        reset = 1'b0;
        exp = '0;
        for (int i = 0; i < 18; i++) begin
            send(32'h300 + 32'(i), 1'b0, 2'd0);
            exp = {exp[543:0], 32'h300 + 32'(i)};
        end
        checks++;
        if (out_ready !== 1'b1 || last_block !== 1'b0 || out !== exp) begin
            failures++;
            $display("FAIL reset_new_block: out_ready=%b last_block=%b out=%h want %h", out_ready, last_block, out, exp);
        end
        ack();
    endtask

    // f_ack in FILL must not disturb the partial block
    task automatic test_fack_in_fill();
        logic [575:0] exp;
        exp = '0;
        for (int i = 0; i < 5; i++) begin
            send(32'h400 + 32'(i), 1'b0, 2'd0);
            exp = {exp[543:0], 32'h400 + 32'(i)};
        end
        ack();
        checks++;
        if (out[159:0] !== exp[159:0] || buffer_full !== 1'b0 || out_ready !== 1'b0) begin
            failures++;
            $display("FAIL fack_fill_hold: out_low=%h want %h buffer_full=%b out_ready=%b", out[159:0], exp[159:0], buffer_full, out_ready);
        end
        for (int i = 5; i < 18; i++) begin
            send(32'h400 + 32'(i), 1'b0, 2'd0);
            exp = {exp[543:0], 32'h400 + 32'(i)};
        end
        checks++;
        if (out_ready !== 1'b1 || out !== exp) begin
            failures++;
            $display("FAIL fack_fill_block: out_ready=%b out=%h want %h", out_ready, out, exp);
        end
        ack();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in       = 32'h0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = 2'd0;
        f_ack    = 1'b0;

        test_reset();
        test_full_block();
        test_single_last();
        test_last_aligned();
        test_last_at(0, 32'hAABBCCDD, 2'd1, 32'hAA060000);
        test_last_at(5, 32'hAABBCCDD, 2'd2, 32'hAABB0600);
        test_last_at(16, 32'h01020304, 2'd3, 32'h01020306);
        test_last_at(17, 32'h01020304, 2'd0, 32'h06000080);
        test_backpressure();
        test_reset_mid_pad();
        test_fack_in_fill();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/padder_ctrl.md
PADDER_CTRL -- requirements
Module: padder_ctrl

Interface
REQ-001 SHALL have parameter RATE_WORDS, default 18, meaning 32-bit words per SHA3-512 rate block (576 bits).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in, input, 32, message word, first byte in in[31:24].
REQ-005 SHALL have port in_ready, input, 1, in/is_last/byte_num valid this cycle.
REQ-006 SHALL have port is_last, input, 1, current word is the final partial word of the message.
REQ-007 SHALL have port byte_num, input, 2, valid bytes in the last word (0..3), used only with is_last.
REQ-008 SHALL have port buffer_full, output, 1, block cannot accept a word this cycle.
REQ-009 SHALL have port out, output, 576, assembled rate block, word 0 in out[575:544].
REQ-010 SHALL have port out_ready, output, 1, out holds a complete block.
REQ-011 SHALL have port last_block, output, 1, current out block ends the message; valid with out_ready.
REQ-012 SHALL have port f_ack, input, 1, consumer has taken out.

Function
REQ-013 SHALL implement states FILL, PAD, FULL; buffer_full = 1 in PAD and FULL, 0 in FILL.
REQ-014 SHALL accept a word when state==FILL and in_ready==1; word shifts in: out <= {out[543:0], w}; word counter cnt increments.
REQ-015 SHALL ignore in_ready, in, is_last and byte_num in PAD and FULL.
REQ-016 Non-last accepted word SHALL be stored unmodified (w = in).
REQ-017 Last accepted word SHALL be padder1(in, byte_num): byte 0x06 placed after the valid bytes, remaining bytes zero.
REQ-018 The final word of a last block (cnt==RATE_WORDS-1) SHALL have 0x80 ORed into its bits [7:0], including when it is the is_last word (e.g. byte_num 3 -> low byte 0x86).
REQ-019 Accepting is_last at cnt<RATE_WORDS-1 SHALL go to PAD; PAD SHALL shift in one zero word per cycle, the final one being 0x00000080, then go to FULL.
REQ-020 Filling the last word (cnt==RATE_WORDS-1) in FILL or PAD SHALL go to FULL at the next edge; out_ready=1 the cycle after that word's accept/shift.
REQ-021 Latency: is_last accepted at index k (<17) in cycle N -> out_ready=1 in cycle N+1+(17-k).
REQ-022 last_block SHALL be set when is_last is accepted and held until f_ack in FULL.
REQ-023 In FULL, f_ack=1 SHALL clear out_ready, last_block, cnt and return to FILL next cycle; out content is don't-care afterwards.
REQ-024 f_ack outside FULL SHALL have no effect.
REQ-025 No extra padding block SHALL ever be generated; a whole-word-aligned message ends with is_last, byte_num=0 as a separate word.
REQ-026 cnt SHALL be 5 bits and never exceed RATE_WORDS-1; no wrap in FILL.

Reset
REQ-027 reset SHALL asynchronously force state FILL, cnt 0, out 0, out_ready 0, last_block 0, buffer_full 0.
REQ-028 reset mid-PAD or mid-FULL SHALL discard the partial/complete block; first word after release is word 0 of a new block.

Structure
REQ-029 Shared package SHALL hold RATE_WORDS=18, RATE_BITS=576, PAD_FIRST=8'h06, PAD_LAST=8'h80 and the FILL/PAD/FULL state encoding.
REQ-030 SHALL instantiate one padder1 sub-module for last-word formatting; no other sub-modules.

Verification
REQ-031 18 words 0x00000001..0x00000012, no is_last -> out_ready one cycle after 18th accept, out = concatenation in order, last_block=0.
REQ-032 First word is_last=1, byte_num=0 -> 17 PAD cycles, out = 0x06000000, sixteen zero words, 0x00000080; last_block=1.
REQ-033 17 words then 0x11223344 is_last, byte_num=3 -> final word 0x11223386, out_ready next cycle, no PAD cycles.
REQ-034 in_ready held high through FULL with f_ack low 5 cycles -> buffer_full=1, out unchanged, no word consumed; f_ack -> FILL, next word lands in word 0.
REQ-035 reset asserted during PAD (k=3) -> all outputs 0 immediately; new 18-word block assembles correctly.
REQ-036 f_ack pulsed in FILL mid-block -> cnt and out unaffected.
